// File: rtl/fft_b4_seq.sv
// Sequencer for a 64-point, 3-stage radix-4 FFT pipeline.
// Drives the input sample index, the stage-1/stage-2 twiddle ROM addresses,
// the pipeline clock-enable and the output sample window. The output window
// opens LAT cycles after the first LOAD cycle of a frame chain. A frame that is
// started back-to-back on the last FLUSH cycle continues the running output
// window without a gap, so out_idx wraps 63 -> 0.
module fft_b4_seq #(
  parameter int LAT = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       enable,
  output logic       in_ready,
  output logic [5:0] sample_idx,
  output logic [5:0] tw_addr_s1,
  output logic [5:0] tw_addr_s2,
  output logic       out_valid,
  output logic [5:0] out_idx,
  output logic       busy,
  output logic       frame_done,
  output logic       start_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic       take;
  logic       drop_nx;
  logic [5:0] idx_nx;

  logic [5:0] load_cnt;
  logic [7:0] flush_cnt;
  logic [5:0] tw1_r;
  logic [5:0] tw2_r;
  logic       drop_r;

  logic [7:0] dly_cnt;
  logic       dly_act;
  logic       dly_hit;
  logic       out_v;
  logic [5:0] out_cnt;
  logic       done_r;
  logic       wrap;

  logic       last_load;
  logic       last_flush;

  // Stage-1 twiddle exponent: (n mod 4) * (n div 4), modulo 64.
  function automatic logic [5:0] tw_s1(input logic [5:0] n);
    return {4'd0, n[1:0]} * {2'd0, n[5:2]};
  endfunction

  // Stage-2 twiddle exponent: ((n mod 4) * ((n div 4) mod 4)) * 4, modulo 64.
  function automatic logic [5:0] tw_s2(input logic [5:0] n);
    logic [5:0] p;
    p = {4'd0, n[1:0]} * {4'd0, n[3:2]};
    return {p[3:0], 2'b00};
  endfunction

  assign last_load  = (state == LOAD)  && (load_cnt == 6'd63);
  assign last_flush = (state == FLUSH) && (flush_cnt == LAT_M1);
  assign dly_hit    = dly_act && (dly_cnt == LAT_M1);
  assign wrap       = out_v && (out_cnt == 6'd63);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; abort wins over everything, a start is only taken in
  // IDLE or on the last FLUSH cycle.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = LOAD;
            take     = 1'b1;
          end
        end
        LOAD: begin
          if (last_load) state_nx = FLUSH;
        end
        FLUSH: begin
          if (last_flush) begin
            if (start) begin
              state_nx = LOAD;
              take     = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    drop_nx = start && !abort && (state != IDLE) && !last_flush;
    idx_nx  = ((state_nx == LOAD) && (state == LOAD)) ? load_cnt + 6'd1 : 6'd0;
  end

  // State-decoded outputs
  always_comb begin
    enable   = (state != IDLE);
    busy     = (state != IDLE);
    in_ready = (state == LOAD);
  end

  // Load/flush counters and registered index, twiddle and drop outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      flush_cnt <= '0;
      tw1_r     <= '0;
      tw2_r     <= '0;
      drop_r    <= 1'b0;
    end else begin
      load_cnt  <= idx_nx;
      flush_cnt <= ((state_nx == FLUSH) && (state == FLUSH)) ? flush_cnt + 8'd1 : 8'd0;
      tw1_r     <= (state_nx == LOAD) ? tw_s1(idx_nx) : 6'd0;
      tw2_r     <= (state_nx == LOAD) ? tw_s2(idx_nx) : 6'd0;
      drop_r    <= drop_nx;
    end
  end

  // Output window: latency delay, then 64 valid samples; continues straight
  // into the next frame when a back-to-back start lands on the wrap cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_act <= 1'b0;
      dly_cnt <= '0;
      out_v   <= 1'b0;
      out_cnt <= '0;
      done_r  <= 1'b0;
    end else if (abort) begin
      dly_act <= 1'b0;
      dly_cnt <= '0;
      out_v   <= 1'b0;
      out_cnt <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= wrap;
      if (take && !wrap) begin
        dly_act <= 1'b1;
        dly_cnt <= '0;
      end else if (dly_act) begin
        if (dly_hit) begin
          dly_act <= 1'b0;
          dly_cnt <= '0;
        end else begin
          dly_cnt <= dly_cnt + 8'd1;
        end
      end
      if (dly_hit) begin
        out_v   <= 1'b1;
        out_cnt <= '0;
      end else if (wrap) begin
        out_v   <= take;
        out_cnt <= '0;
      end else if (out_v) begin
        out_cnt <= out_cnt + 6'd1;
      end
    end
  end

  assign sample_idx = load_cnt;
  assign tw_addr_s1 = tw1_r;
  assign tw_addr_s2 = tw2_r;
  assign out_valid  = out_v;
  assign out_idx    = out_cnt;
  assign frame_done = done_r;
  assign start_drop = drop_r;

endmodule
